// File: rtl/operand_bank.sv
// operand_bank: paired A/B operand banks with a ready/valid burst loader and
// two registered read ports for the ECC multiplier cores.
// Core 1 serves half-word recombinations; core 2 serves MSB/LSB half pairs.
// Optional build macro: OPERAND_BANK_BYPASS_EN (same-cycle write-to-read forwarding).
module operand_bank #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data_a,
    input  logic [DATA_W-1:0] in_data_b,
    output logic              load_done,
    output logic              full,
    input  logic              c1_rd_en,
    input  logic [ADDR_W-1:0] c1_addr_1,
    input  logic [ADDR_W-1:0] c1_addr_2,
    input  logic [1:0]        c1_mode,
    input  logic              c1_msb,
    output logic [DATA_W-1:0] c1_data,
    output logic              c1_valid,
    input  logic              c2_rd_en,
    input  logic [ADDR_W-1:0] c2_addr,
    input  logic              c2_msb,
    output logic [DATA_W-1:0] c2_data,
    output logic              c2_valid,
    output logic [1:0]        rd_err
);

    localparam int unsigned H = DATA_W / 2;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              full_q, full_d;
    logic              load_done_q, load_done_d;
    logic [DATA_W-1:0] a_mem_q [DEPTH];
    logic [DATA_W-1:0] a_mem_d [DEPTH];
    logic [DATA_W-1:0] b_mem_q [DEPTH];
    logic [DATA_W-1:0] b_mem_d [DEPTH];

    logic [DATA_W-1:0] a_rd [DEPTH];
    logic [DATA_W-1:0] b_rd [DEPTH];

    logic [DATA_W-1:0] c1_data_q, c1_data_d;
    logic              c1_valid_q, c1_valid_d;
    logic [DATA_W-1:0] c2_data_q, c2_data_d;
    logic              c2_valid_q, c2_valid_d;
    logic [1:0]        rd_err_q, rd_err_d;

    logic [ADDR_W-1:0] c1_i1, c1_i2, c2_i;
    logic              c1_bad, c2_bad;
    logic [DATA_W-1:0] c1_word, c2_word;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < DEPTH;
    endfunction

    // Load sequencer: restart on load_start (dropping any coincident beat), else accept beats in LOAD
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        full_d      = full_q;
        load_done_d = 1'b0;
        a_mem_d     = a_mem_q;
        b_mem_d     = b_mem_q;
        if (load_start) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            full_d   = 1'b0;
        end else if (state_q == LOAD && in_valid) begin
            a_mem_d[wr_ptr_q] = in_data_a;
            b_mem_d[wr_ptr_q] = in_data_b;
            if (wr_ptr_q == LAST_PTR) begin
                state_d     = IDLE;
                full_d      = 1'b1;
                load_done_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end
    end

    // Read view of the banks: post-write image when forwarding, else current contents
    always_comb begin
`ifdef OPERAND_BANK_BYPASS_EN
        a_rd = a_mem_d;
        b_rd = b_mem_d;
`else
        a_rd = a_mem_q;
        b_rd = b_mem_q;
`endif
    end

    // Core 1 port: recombine halves, zero the result on any out-of-range referenced entry
    always_comb begin
        c1_i1  = in_range(c1_addr_1) ? c1_addr_1 : '0;
        c1_i2  = in_range(c1_addr_2) ? c1_addr_2 : '0;
        c1_bad = !in_range(c1_addr_1) || (c1_mode != 2'd3 && !in_range(c1_addr_2));
        case (c1_mode)
            2'd0: c1_word = c1_msb ? {a_rd[c1_i1][DATA_W-1:H], b_rd[c1_i2][DATA_W-1:H]}
                                   : {a_rd[c1_i1][H-1:0],      b_rd[c1_i2][H-1:0]};
            2'd1: c1_word = {a_rd[c1_i1][DATA_W-1:H], a_rd[c1_i2][H-1:0]};
            2'd2: c1_word = {b_rd[c1_i1][DATA_W-1:H], b_rd[c1_i2][H-1:0]};
            default: c1_word = a_rd[c1_i1];
        endcase
        c1_valid_d = c1_rd_en;
        c1_data_d  = c1_data_q;
        if (c1_rd_en) begin
            c1_data_d = c1_bad ? '0 : c1_word;
        end
    end

    // Core 2 port: A/B half pair from a single entry
    always_comb begin
        c2_i    = in_range(c2_addr) ? c2_addr : '0;
        c2_bad  = !in_range(c2_addr);
        c2_word = c2_msb ? {a_rd[c2_i][DATA_W-1:H], b_rd[c2_i][DATA_W-1:H]}
                         : {a_rd[c2_i][H-1:0],      b_rd[c2_i][H-1:0]};
        c2_valid_d = c2_rd_en;
        c2_data_d  = c2_data_q;
        if (c2_rd_en) begin
            c2_data_d = c2_bad ? '0 : c2_word;
        end
        rd_err_d = {c2_rd_en && c2_bad, c1_rd_en && c1_bad};
    end

    // State, storage and read-port registers; reset clears storage too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            full_q      <= 1'b0;
            load_done_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                a_mem_q[i] <= '0;
                b_mem_q[i] <= '0;
            end
            c1_data_q  <= '0;
            c1_valid_q <= 1'b0;
            c2_data_q  <= '0;
            c2_valid_q <= 1'b0;
            rd_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            load_done_q <= load_done_d;
            a_mem_q     <= a_mem_d;
            b_mem_q     <= b_mem_d;
            c1_data_q   <= c1_data_d;
            c1_valid_q  <= c1_valid_d;
            c2_data_q   <= c2_data_d;
            c2_valid_q  <= c2_valid_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign load_done = load_done_q;
    assign full      = full_q;
    assign c1_data   = c1_data_q;
    assign c1_valid  = c1_valid_q;
    assign c2_data   = c2_data_q;
    assign c2_valid  = c2_valid_q;
    assign rd_err    = rd_err_q;

endmodule
